// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: opcode encodings, FSM state type and flag bit positions.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROTL = 4'h6;
  localparam logic [3:0] OP_ROTR = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_LT   = 4'hF;

  typedef enum logic [0:0] {S_IDLE, S_DIV} state_e;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_NEG   = 2;

endpackage

// File: rtl/alu_seq_div.sv
// Iterative restoring divider: one quotient bit per cycle for W cycles after start.
// quotient/remainder carry the final values combinationally in the cycle done is high.
module alu_seq_div #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int unsigned CntW = $clog2(W + 1);

  logic            active_q;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    rem_q, quo_q, dvs_q;
  logic [W:0]      rem_sh, diff;

  // diff[W] set means the trial subtraction borrowed, so the partial remainder is restored.
  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (diff[W]) begin
      remainder = rem_sh[W-1:0];
      quotient  = {quo_q[W-2:0], 1'b0};
    end else begin
      remainder = diff[W-1:0];
      quotient  = {quo_q[W-2:0], 1'b1};
    end
  end

  assign done = active_q && (cnt_q == CntW'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= CntW'(W);
      rem_q    <= '0;
      quo_q    <= dividend;
      dvs_q    <= divisor;
    end else if (active_q) begin
      rem_q    <= remainder;
      quo_q    <= quotient;
      cnt_q    <= cnt_q - CntW'(1);
      active_q <= !done;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential W-bit ALU with 2W-bit registered result, multi-cycle divide and per-opcode
// last-result table. Optional flags output is enabled by defining ALU_SEQ_FLAGS_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           data_valid,
  input  logic [3:0]     op,
  input  logic           op_valid,
  output logic           op_ready,
  output logic [2*W-1:0] result,
  output logic           result_valid,
  output logic           busy,
  output logic           div_by_zero,
  input  logic [3:0]     rd_op,
  output logic [2*W-1:0] rd_data
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic [2:0]     flags
`endif
);

  state_e         state_q, state_d;
  logic [W-1:0]   a_lat_q, b_lat_q, op_a, op_b;
  logic [2*W-1:0] a_ext, b_ext, alu_res;
  logic           accept, div_start, div_done;
  logic [W-1:0]   div_quo, div_rem;
  logic           wr_en, wr_dbz;
  logic [3:0]     wr_idx;
  logic [2*W-1:0] wr_data;
  logic [2*W-1:0] table_q [16];

  assign op_a      = data_valid ? a_i : a_lat_q;
  assign op_b      = data_valid ? b_i : b_lat_q;
  assign accept    = op_valid && op_ready;
  assign div_start = accept && (op == OP_DIV) && (op_b != '0);

  always_comb begin
    a_ext   = {{W{1'b0}}, op_a};
    b_ext   = {{W{1'b0}}, op_b};
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_MUL:  alu_res = a_ext * b_ext;
      // Only reaches the result path when the divisor is zero.
      OP_DIV:  alu_res = {op_a, {W{1'b1}}};
      OP_SHL:  alu_res = a_ext << 1;
      OP_SHR:  alu_res = a_ext >> 1;
      OP_ROTL: alu_res = {{W{1'b0}}, op_a[W-2:0], op_a[W-1]};
      OP_ROTR: alu_res = {{W{1'b0}}, op_a[0], op_a[W-1:1]};
      OP_AND:  alu_res = {{W{1'b0}}, op_a & op_b};
      OP_OR:   alu_res = {{W{1'b0}}, op_a | op_b};
      OP_XOR:  alu_res = {{W{1'b0}}, op_a ^ op_b};
      OP_NOR:  alu_res = {{W{1'b0}}, ~(op_a | op_b)};
      OP_NAND: alu_res = {{W{1'b0}}, ~(op_a & op_b)};
      OP_XNOR: alu_res = {{W{1'b0}}, ~(op_a ^ op_b)};
      OP_GT:   alu_res = {{(2*W-1){1'b0}}, op_a > op_b};
      OP_LT:   alu_res = {{(2*W-1){1'b0}}, op_a < op_b};
      default: alu_res = '0;
    endcase
  end

  alu_seq_div #(
    .W(W)
  ) u_div (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .dividend  (op_a),
    .divisor   (op_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (div_start) state_d = S_DIV;
      S_DIV:   if (div_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_ready = (state_q == S_IDLE);
    busy     = (state_q == S_DIV);
  end

  // One write port shared by single-cycle ops and divide completion.
  always_comb begin
    wr_en   = 1'b0;
    wr_dbz  = 1'b0;
    wr_idx  = op;
    wr_data = alu_res;
    if (state_q == S_DIV) begin
      wr_en   = div_done;
      wr_idx  = OP_DIV;
      wr_data = {div_rem, div_quo};
    end else if (accept && !div_start) begin
      wr_en  = 1'b1;
      wr_dbz = (op == OP_DIV);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_lat_q      <= '0;
      b_lat_q      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      div_by_zero  <= 1'b0;
      rd_data      <= '0;
      for (int i = 0; i < 16; i++) table_q[i] <= '0;
    end else begin
      if (data_valid) begin
        a_lat_q <= a_i;
        b_lat_q <= b_i;
      end
      result_valid <= wr_en;
      div_by_zero  <= wr_en && wr_dbz;
      if (wr_en) begin
        result          <= wr_data;
        table_q[wr_idx] <= wr_data;
      end
      rd_data <= (wr_en && (wr_idx == rd_op)) ? wr_data : table_q[rd_op];
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [2:0] flags_d;

  always_comb begin
    flags_d             = '0;
    flags_d[FLAG_ZERO]  = (wr_data == '0);
    flags_d[FLAG_NEG]   = wr_data[W-1];
    if (state_q == S_IDLE) begin
      if (op == OP_ADD) flags_d[FLAG_CARRY] = alu_res[W];
      if (op == OP_SUB) flags_d[FLAG_CARRY] = (op_a < op_b);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flags <= '0;
    end else if (wr_en) begin
      flags <= flags_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=8) against an arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int unsigned W = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [W-1:0]   a_i, b_i;
  logic           data_valid;
  logic [3:0]     op;
  logic           op_valid;
  logic           op_ready;
  logic [2*W-1:0] result;
  logic           result_valid;
  logic           busy;
  logic           div_by_zero;
  logic [3:0]     rd_op;
  logic [2*W-1:0] rd_data;
`ifdef ALU_SEQ_FLAGS_EN
  logic [2:0]     flags;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  la, lb;
  logic [15:0] hist [16];

  alu_seq #(
    .W(W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .a_i          (a_i),
    .b_i          (b_i),
    .data_valid   (data_valid),
    .op           (op),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .div_by_zero  (div_by_zero),
    .rd_op        (rd_op),
    .rd_data      (rd_data)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flags        (flags)
`endif
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] ref_alu(input logic [3:0] o, input int unsigned a,
                                          input int unsigned b);
    int unsigned r;
    case (o)
      4'h0: r = a + b;
      4'h1: r = (a - b) & 32'hFFFF;
      4'h2: r = a * b;
      4'h3: r = (b == 0) ? a * 256 + 255 : (a % b) * 256 + a / b;
      4'h4: r = a * 2;
      4'h5: r = a / 2;
      4'h6: r = (a * 2) % 256 + a / 128;
      4'h7: r = a / 2 + (a % 2) * 128;
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = ~(a | b) & 255;
      4'hC: r = ~(a & b) & 255;
      4'hD: r = ~(a ^ b) & 255;
      4'hE: r = (a > b) ? 1 : 0;
      default: r = (a < b) ? 1 : 0;
    endcase
    return r[15:0];
  endfunction

  // Drives one request (DUT must be idle) and predicts its outcome from the operand model.
  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic dv, output logic [15:0] exp, output logic exp_dbz);
    logic [7:0] ea, eb;
    ea = dv ? a : la;
    eb = dv ? b : lb;
    if (dv) begin
      la = a;
      lb = b;
    end
    exp     = ref_alu(o, ea, eb);
    exp_dbz = (o == 4'h3) && (eb == 8'h00);
    hist[o] = exp;
    op = o; a_i = a; b_i = b; data_valid = dv; op_valid = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (result !== 16'h0 || result_valid !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b0
        || op_ready !== 1'b1 || rd_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: result=%h rv=%b dbz=%b busy=%b rdy=%b rd=%h",
               result, result_valid, div_by_zero, busy, op_ready, rd_data);
    end
    for (int i = 0; i < 16; i++) begin
      rd_op = 4'(i);
      cyc();
      n_checks++;
      if (rd_data !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_table[%0d]: got %h expected 0000", i, rd_data);
      end
    end
    rd_op = 4'h0;
  endtask

  task automatic test_add();
    logic [15:0] exp;
    logic dbz;
    issue(OP_ADD, 8'd200, 8'd100, 1'b1, exp, dbz);
    cyc();
    op_valid = 1'b0; data_valid = 1'b0;
    n_checks++;
    if (result_valid !== 1'b1 || result !== 16'h012C) begin
      n_fail++;
      $display("FAIL add: rv=%b result=%h expected rv=1 result=012C", result_valid, result);
    end
    cyc();
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_pulse: result_valid=%b expected 0", result_valid);
    end
  endtask

  task automatic test_operand_reuse();
    logic [15:0] exp;
    logic dbz;
    a_i = 8'd7; b_i = 8'd3; data_valid = 1'b1; la = 8'd7; lb = 8'd3;
    cyc();
    data_valid = 1'b0; a_i = 8'hEE; b_i = 8'h55;
    cyc();
    issue(OP_MUL, 8'hEE, 8'h55, 1'b0, exp, dbz);
    cyc();
    op_valid = 1'b0;
    n_checks++;
    if (result_valid !== 1'b1 || result !== 16'd21) begin
      n_fail++;
      $display("FAIL reuse_mul: rv=%b result=%h expected 0015", result_valid, result);
    end
    issue(OP_ROTL, 8'h81, 8'h00, 1'b1, exp, dbz);
    cyc();
    op_valid = 1'b0; data_valid = 1'b0;
    n_checks++;
    if (result !== 16'h0003) begin
      n_fail++;
      $display("FAIL rotl: got %h expected 0003", result);
    end
  endtask

  task automatic test_divide();
    logic [15:0] exp;
    logic dbz;
    int lat, low;
    issue(OP_DIV, 8'd200, 8'd7, 1'b1, exp, dbz);
    cyc();
    op_valid = 1'b0; data_valid = 1'b0;
    lat = 0; low = 0;
    for (int k = 1; k <= 2 * W + 4; k++) begin
      if (k == 3) begin
        op = OP_ADD; a_i = 8'd1; b_i = 8'd1; data_valid = 1'b1; op_valid = 1'b1;
        la = 8'd1; lb = 8'd1;
      end
      if (k == 5) begin
        op_valid = 1'b0; data_valid = 1'b0;
      end
      if (result_valid) begin
        lat = k;
        break;
      end
      if (!op_ready) low++;
      cyc();
    end
    n_checks++;
    if (lat != W + 1) begin
      n_fail++;
      $display("FAIL div_latency: got %0d expected %0d", lat, W + 1);
    end
    n_checks++;
    if (low != W) begin
      n_fail++;
      $display("FAIL div_busy_cycles: got %0d expected %0d", low, W);
    end
    n_checks++;
    if (result !== 16'h041C || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL div_result: got %h dbz=%b expected 041C dbz=0", result, div_by_zero);
    end
    cyc();
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL div_ignored_op: result_valid=%b expected 0", result_valid);
    end
  endtask

  task automatic test_history();
    logic [15:0] exp;
    logic dbz;
    rd_op = 4'h0;
    cyc();
    n_checks++;
    if (rd_data !== 16'h012C) begin
      n_fail++;
      $display("FAIL hist_add: got %h expected 012C", rd_data);
    end
    rd_op = 4'h3;
    cyc();
    n_checks++;
    if (rd_data !== 16'h041C) begin
      n_fail++;
      $display("FAIL hist_div: got %h expected 041C", rd_data);
    end
    rd_op = OP_XOR;
    issue(OP_XOR, 8'($urandom), 8'($urandom), 1'b1, exp, dbz);
    cyc();
    op_valid = 1'b0; data_valid = 1'b0;
    n_checks++;
    if (rd_data !== exp || result !== exp) begin
      n_fail++;
      $display("FAIL hist_write_first: rd=%h result=%h expected %h", rd_data, result, exp);
    end
  endtask

  task automatic test_div_zero();
    logic [15:0] exp;
    logic dbz;
    issue(OP_DIV, 8'd5, 8'd0, 1'b1, exp, dbz);
    cyc();
    op_valid = 1'b0; data_valid = 1'b0;
    n_checks++;
    if (result_valid !== 1'b1 || result !== 16'h05FF || div_by_zero !== 1'b1 || busy !== 1'b0)
    begin
      n_fail++;
      $display("FAIL div_zero: rv=%b result=%h dbz=%b busy=%b expected 1 05FF 1 0",
               result_valid, result, div_by_zero, busy);
    end
    cyc();
    n_checks++;
    if (div_by_zero !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL div_zero_pulse: dbz=%b busy=%b expected 0 0", div_by_zero, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    logic dbz;
    logic [3:0] o;
    for (int i = 0; i < 10; i++) begin
      do o = 4'($urandom_range(0, 15)); while (o == OP_DIV);
      issue(o, 8'($urandom), 8'($urandom), ($urandom_range(0, 1) == 1), exp, dbz);
      cyc();
      n_checks++;
      if (result_valid !== 1'b1 || result !== exp) begin
        n_fail++;
        $display("FAIL b2b[%0d] op=%h: rv=%b result=%h expected %h", i, o, result_valid,
                 result, exp);
      end
    end
    op_valid = 1'b0; data_valid = 1'b0;
    cyc();
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: result_valid=%b expected 0", result_valid);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    logic dbz;
    logic [3:0] o, ro;
    int lat, exp_lat;
    for (int i = 0; i < 60; i++) begin
      o  = 4'($urandom_range(0, 15));
      ro = 4'($urandom_range(0, 15));
      rd_op = ro;
      issue(o, 8'($urandom), ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
            ($urandom_range(0, 3) != 0), exp, dbz);
      exp_lat = (o == OP_DIV && !dbz) ? W + 1 : 1;
      cyc();
      op_valid = 1'b0; data_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 2 * W + 4; k++) begin
        if (result_valid) begin
          lat = k;
          break;
        end
        cyc();
      end
      n_checks++;
      if (lat != exp_lat) begin
        n_fail++;
        $display("FAIL rand_latency[%0d] op=%h: got %0d expected %0d", i, o, lat, exp_lat);
      end
      n_checks++;
      if (result !== exp || div_by_zero !== dbz) begin
        n_fail++;
        $display("FAIL rand_result[%0d] op=%h: got %h dbz=%b expected %h dbz=%b", i, o,
                 result, div_by_zero, exp, dbz);
      end
      cyc();
      n_checks++;
      if (rd_data !== hist[ro]) begin
        n_fail++;
        $display("FAIL rand_hist[%0d] idx=%h: got %h expected %h", i, ro, rd_data, hist[ro]);
      end
    end
  endtask

  task automatic test_reset_during_div();
    logic [15:0] exp;
    logic dbz;
    int stray, bad;
    issue(OP_DIV, 8'd250, 8'd3, 1'b1, exp, dbz);
    cyc();
    op_valid = 1'b0; data_valid = 1'b0;
    repeat (3) cyc();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy: busy=%b expected 1", busy);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    la = 8'h00; lb = 8'h00;
    for (int i = 0; i < 16; i++) hist[i] = 16'h0;
    n_checks++;
    if (result !== 16'h0 || result_valid !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b0
        || op_ready !== 1'b1 || rd_data !== 16'h0) begin
      n_fail++;
      $display("FAIL abort_outputs: result=%h rv=%b dbz=%b busy=%b rdy=%b rd=%h",
               result, result_valid, div_by_zero, busy, op_ready, rd_data);
    end
    stray = 0;
    for (int k = 0; k < 2 * W; k++) begin
      cyc();
      if (result_valid) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL abort_no_result: got %0d pulses expected 0", stray);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      rd_op = 4'(i);
      cyc();
      if (rd_data !== 16'h0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_table: got %0d nonzero entries expected 0", bad);
    end
    issue(OP_NAND, 8'hA5, 8'h5A, 1'b0, exp, dbz);
    cyc();
    op_valid = 1'b0;
    n_checks++;
    if (result !== exp) begin
      n_fail++;
      $display("FAIL abort_latches: got %h expected %h", result, exp);
    end
  endtask

  initial begin
    reset = 1'b1; a_i = '0; b_i = '0; data_valid = 1'b0; op = '0; op_valid = 1'b0;
    rd_op = '0; la = '0; lb = '0;
    for (int i = 0; i < 16; i++) hist[i] = 16'h0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    test_reset();
    test_add();
    test_operand_reuse();
    test_divide();
    test_history();
    test_div_zero();
    test_back_to_back();
    test_random();
    test_reset_during_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised successor to the team's single-cycle 8-bit ALU. It has W-bit operands and a 2W-bit result, with a valid/ready handshake on operations.
- Divide is multi-cycle (iterative restoring divider) and returns quotient and remainder.
- A 16-entry last-result table, indexed by opcode, provides a 1-cycle-latency readback port.
- The block sits between the operand/control sequencer and the result bus.

Parameters:
W, 8, operand width (>=2); result width is 2*W

Ports:
clock  in  1  single system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
a_i  in  W  operand A
b_i  in  W  operand B
data_valid  in  1  a_i/b_i valid this cycle; latched into operand registers
op  in  4  opcode
op_valid  in  1  operation request
op_ready  out  1  block can accept op (= not busy)
result  out  2W  registered result
result_valid  out  1  one-cycle pulse per completed op
busy  out  1  divider running
div_by_zero  out  1  pulses with result_valid when a divide had b==0
rd_op  in  4  history table read index
rd_data  out  2W  last result of opcode rd_op, registered

Behaviour:
- Reset: result=0, result_valid=0, div_by_zero=0, busy=0, rd_data=0, latched operands=0, all 16 table entries=0, FSM->IDLE.
- Operand select: data_valid=1 selects a_i/b_i; otherwise the latched values are used. Latches update on every data_valid, including while busy; a running divide keeps its own captured operands.
- Accept: the op is taken at the edge where op_valid & op_ready. Requests while busy are ignored; the requester holds op_valid until accepted.
- FSM IDLE:
  - Non-divide op: result registered at the accept edge, result_valid high the next cycle (latency 1).
  - Divide with b==0: same latency 1; result={a,{W{1'b1}}}, div_by_zero=1.
  - Divide with b!=0: go to DIV.
- FSM DIV: busy=1, op_ready=0. The divider runs W iteration cycles. At the final edge it returns to IDLE and registers result={remainder,quotient}; result_valid pulses in the following cycle. Total latency is W+1 clocks from accept.
- Opcodes. Unsigned; W-bit results are zero-extended to 2W.
  - 0 add, 1 sub (2W two's-complement wrap), 2 mul (full 2W), 3 div.
  - 4 shl by 1 (2W, keeps bit W), 5 shr by 1.
  - 6 rotl, 7 rotr (W-bit).
  - 8 and, 9 or, A xor, B nor, C nand, D xnor.
  - E a>b, F a<b (1/0).
- History table: written at the same edge that result is registered, at the index of the producing op. rd_data = table[rd_op] one cycle later. A read and write to the same index in the same cycle returns the new value (write-first).
- Reset during DIV: aborts; no result_valid; op_ready=1 in the cycle after reset deasserts.

Optional Feature:
ALU_SEQ_FLAGS_EN:
- When defined, adds output flags[2:0], registered alongside result:
  - [0] zero: result==0.
  - [1] carry: bit W of result for add; borrow for sub; 0 otherwise.
  - [2] neg: bit W-1 of result.
- flags resets to 0.
- When not defined, the port and its logic are absent and behaviour is otherwise identical.

Decomposition:
- Package alu_seq_pkg: opcode localparams OP_ADD..OP_LT (4'h0..4'hF), FSM state type {S_IDLE,S_DIV}, flag bit indices.
- Sub-module alu_seq_div (parameter W): start/done interface; W-cycle restoring divider with quotient/remainder outputs and synchronous reset.

Test Plan:
1. Add, W=8: data_valid with a=200, b=100, op=0, op_valid -> next cycle result=16'h012C, result_valid high exactly 1 cycle.
2. Operand reuse: data_valid with 7,3; later op=2 with data_valid=0 -> result=21. Also op=6 on a=0x81 -> 16'h0003.
3. Divide: a=200, b=7, op=3 -> op_ready low 8 cycles; result=16'h041C at W+1=9 clocks. An op issued mid-divide is ignored.
4. Divide by zero: a=5, b=0, op=3 -> 1 cycle later result=16'h05FF, div_by_zero=1, busy never asserted.
5. History: after tests 1 and 3, rd_op=0 -> rd_data=16'h012C next cycle; rd_op=3 -> 16'h041C. Same-cycle write/read of an index returns the new value.
6. Reset asserted on the 4th divide cycle -> no result_valid; all outputs 0; table cleared; op_ready=1 after release.
